bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//  Downstream consumer of the single-port image/weight BRAM. On a start
//  command, reads LEN consecutive words from BASE and delivers them as a
//  valid/ready stream to the CNN datapath. It hides the one-cycle BRAM read
//  latency and absorbs back-pressure with a 2-entry output buffer, giving
//  one word per clock when the sink is always ready.
// PARAMETERS
//  W_DATA  32  word width; matches BRAM W_DATA
//  W_WORD  4   BRAM address width; BRAM depth is 2**W_WORD
//  W_LEN   5   width of len; max transfer = 2**W_LEN-1 words
// PORTS
//  clk        in   1       clock, rising edge
//  rstn       in   1       asynchronous active-low reset
//  start      in   1       one-cycle command strobe; sampled only in IDLE
//  base_addr  in   W_WORD  first BRAM word address
//  len        in   W_LEN   number of words to read
//  busy       out  1       high from accepted start until done
//  done       out  1       one-cycle pulse at end of transfer
//  bram_en    out  1       BRAM enable; high only on issued read cycles
//  bram_we    out  1       tied 0; this block never writes
//  bram_addr  out  W_WORD  BRAM read address
//  bram_dout  in   W_DATA  BRAM read data, valid 1 cycle after bram_en
//  m_valid    out  1       stream data valid
//  m_ready    in   1       stream sink ready
//  m_data     out  W_DATA  stream word
//  m_last     out  1       high with the final word of a transfer
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM=IDLE; busy, done, bram_en,
//    m_valid, m_last=0; bram_addr, m_data=0; buffer empty; counters cleared.
//  - FSM: IDLE -(start & len!=0)-> RUN -(all len reads issued)-> DRAIN
//    -(last word accepted)-> IDLE. start & len==0: done pulses next cycle,
//    no BRAM access, busy stays 0.
//  - base_addr and len are latched on the accepted start. start while busy
//    is ignored.
//  - Read issue in RUN: bram_en=1 when (buffer free entries - reads in
//    flight) > 0. Each issue increments bram_addr modulo 2**W_WORD (wraps
//    from 2**W_WORD-1 to 0) and decrements the remaining count.
//  - Capture: bram_dout is written into the buffer on the cycle after each
//    issue, unconditionally. The buffer never overflows. BRAM holds dout
//    while en=0, but the block does not rely on that.
//  - Stream: a word transfers when m_valid & m_ready. Once asserted,
//    m_valid, m_data and m_last hold stable until accepted. With m_ready
//    held at 1, the first word appears 2 cycles after start and then one
//    word every cycle.
//  - m_last=1 only on word number len of the transfer.
//  - done pulses the cycle after the m_last handshake. busy falls in the
//    same cycle as that pulse. A new start is accepted in the cycle done=1.
//  - Buffer simultaneous push and pop: occupancy unchanged, order preserved.
//  - Reset mid-transfer: everything returns to reset values immediately.
//    Partially delivered data is discarded and done does not pulse.
// CONFIGURATION
//  BRAM_RD_STALL_CNT_EN defined: adds output port stall_cnt[15:0]. It
//   clears on accepted start, increments each busy cycle with
//   m_valid & !m_ready, and saturates at 16'hFFFF. It holds after done.
//  BRAM_RD_STALL_CNT_EN undefined: the port and its logic are absent.
//   All other behaviour is identical.
// TESTING
//  1. base=0, len=16, m_ready=1 -> bram_addr 0..15 on consecutive cycles.
//     Words are output in order, m_last on word 16, done 1 cycle later.
//  2. base=14, len=4 -> addresses 14,15,0,1 (wrap). Stream matches BRAM
//     contents at those addresses.
//  3. len=8, m_ready toggling 1,0,0,1 -> no word lost or duplicated.
//     bram_en=0 whenever the buffer plus in-flight reads reach 2.
//     m_data is stable while m_valid & !m_ready.
//  4. len=0 -> done pulse next cycle; bram_en, m_valid and busy stay 0.
//     start during busy -> ignored, no extra reads.
//  5. rstn low after 3 of 10 words -> outputs reset asynchronously.
//     A new start with len=2 then streams correctly.
//  6. BRAM_RD_STALL_CNT_EN: len=4, m_ready=0 for 5 busy cycles with
//     m_valid=1 -> stall_cnt=5 at done.

Source files
------------

// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: the BRAM read port plus the
// valid/ready output stream. "master" is the reader side; "slave" is the
// BRAM/sink side.
interface bram_stream_reader_if #(
  parameter int W_DATA = 32,
  parameter int W_WORD = 4
);
  logic              bram_en;
  logic              bram_we;
  logic [W_WORD-1:0] bram_addr;
  logic [W_DATA-1:0] bram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [W_DATA-1:0] m_data;
  logic              m_last;

  modport master (
    output bram_en, bram_we, bram_addr,
    input  bram_dout,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  bram_en, bram_we, bram_addr,
    output bram_dout,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: on start, reads len consecutive BRAM words from
// base_addr (address wraps modulo the BRAM depth) and streams them out over
// valid/ready. A 2-entry buffer absorbs back-pressure; a word still in
// flight from the BRAM is presented directly when the buffer is empty, so a
// always-ready sink sees the first word two cycles after start and then one
// word per clock.
// Optional feature: define BRAM_RD_STALL_CNT_EN to add the stall_cnt output.
module bram_stream_reader #(
  parameter int W_DATA = 32,
  parameter int W_WORD = 4,
  parameter int W_LEN  = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [W_WORD-1:0] base_addr,
  input  logic [W_LEN-1:0]  len,
  output logic              busy,
  output logic              done,
`ifdef BRAM_RD_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  bram_stream_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [W_LEN-1:0] LEN_ONE = W_LEN'(1);

  state_t            state_reg, state_next;
  logic [W_WORD-1:0] addr_reg;
  logic [W_LEN-1:0]  rem_reg;
  logic              pend_reg;       // a BRAM read was issued last cycle
  logic              pend_last_reg;  // ... and it was the final word
  logic [1:0]        cnt_reg;        // buffer occupancy, 0..2
  logic [W_DATA-1:0] buf_data_reg [2];
  logic              buf_last_reg [2];
  logic              done_reg;

  logic              issue;
  logic              accept;
  logic              zero_start;
  logic              valid_w;
  logic              last_w;
  logic [W_DATA-1:0] data_w;
  logic              pop;
  logic              push_store;
  logic [1:0]        wr_idx;

  // Output stream view: buffer head if occupied, else the word arriving from BRAM.
  assign valid_w    = (cnt_reg != 2'd0) | pend_reg;
  assign data_w     = (cnt_reg != 2'd0) ? buf_data_reg[0] : (pend_reg ? bus.bram_dout : '0);
  assign last_w     = (cnt_reg != 2'd0) ? buf_last_reg[0] : (pend_reg & pend_last_reg);
  assign pop        = valid_w & bus.m_ready;
  // An arriving word bypassed and accepted in the same cycle never enters the buffer.
  assign push_store = pend_reg & ~((cnt_reg == 2'd0) & pop);
  assign wr_idx     = cnt_reg - {1'b0, pop};

  assign accept     = (state_reg == IDLE) & start;
  assign zero_start = accept & (len == '0);

  assign bus.m_valid   = valid_w;
  assign bus.m_data    = data_w;
  assign bus.m_last    = last_w;
  assign bus.bram_en   = issue;
  assign bus.bram_we   = 1'b0;
  assign bus.bram_addr = addr_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state and read issue: issue only while buffer space exceeds reads in flight.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && (len != '0)) state_next = RUN;
      end
      RUN: begin
        issue = ((cnt_reg + {1'b0, pend_reg}) < 2'd2);
        if (issue && (rem_reg == LEN_ONE)) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && last_w) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/remaining counters, in-flight tracking, occupancy and done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_reg      <= '0;
      rem_reg       <= '0;
      pend_reg      <= 1'b0;
      pend_last_reg <= 1'b0;
      cnt_reg       <= 2'd0;
      done_reg      <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg <= base_addr;
        rem_reg  <= len;
      end else if (issue) begin
        addr_reg <= addr_reg + 1'b1;
        rem_reg  <= rem_reg - 1'b1;
      end
      pend_reg      <= issue;
      pend_last_reg <= issue & (rem_reg == LEN_ONE);
      cnt_reg       <= cnt_reg + {1'b0, pend_reg} - {1'b0, pop};
      done_reg      <= (pop & last_w) | zero_start;
    end
  end

  // Two-entry buffer: pop shifts entry 1 to the head; arriving word lands behind survivors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_data_reg[0] <= '0;
      buf_data_reg[1] <= '0;
      buf_last_reg[0] <= 1'b0;
      buf_last_reg[1] <= 1'b0;
    end else begin
      if (pop) begin
        buf_data_reg[0] <= buf_data_reg[1];
        buf_last_reg[0] <= buf_last_reg[1];
      end
      if (push_store) begin
        if (wr_idx[0]) begin
          buf_data_reg[1] <= bus.bram_dout;
          buf_last_reg[1] <= pend_last_reg;
        end else begin
          buf_data_reg[0] <= bus.bram_dout;
          buf_last_reg[0] <= pend_last_reg;
        end
      end
    end
  end

`ifdef BRAM_RD_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;
  assign stall_cnt = stall_cnt_reg;

  // Count busy cycles where the sink stalls a valid word; saturating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_reg <= 16'd0;
    end else if (accept) begin
      stall_cnt_reg <= 16'd0;
    end else if (busy && valid_w && !bus.m_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: a behavioural BRAM plus a queue-based
// reference of the expected word stream, with randomized sink back-pressure.
module tb_bram_stream_reader;
  localparam int W_DATA = 32;
  localparam int W_WORD = 4;
  localparam int W_LEN  = 5;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [W_WORD-1:0] base_addr = '0;
  logic [W_LEN-1:0]  len = '0;
  logic              busy;
  logic              done;
`ifdef BRAM_RD_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  bram_stream_reader_if #(.W_DATA(W_DATA), .W_WORD(W_WORD)) bus ();

  bram_stream_reader #(.W_DATA(W_DATA), .W_WORD(W_WORD), .W_LEN(W_LEN)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
`ifdef BRAM_RD_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM, one-cycle read latency.
  logic [W_DATA-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: begin
        case (cyc % 4)
          0: return 1'b1;
          1: return 1'b0;
          2: return 1'b0;
          default: return 1'b1;
        endcase
      end
      3: return !(cyc >= 2 && cyc <= 6);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One transfer: cycle 0 is the negedge where start is driven; every later
  // negedge observes outputs, then chooses m_ready for that cycle.
  task automatic run_xfer(input int base, input int n, input int mode, input bit poke);
    logic [W_DATA-1:0] exp_q[$];
    int issued = 0, accepted = 0, cyc = 0, first_valid = -1, last_hs = -1, stall_model = 0;
    bit finished = 0, prev_stall = 0, rdy;
    logic [W_DATA-1:0] prev_data = '0, exp_word;
    logic prev_last = 1'b0;

    for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    start = 1'b1;
    base_addr = W_WORD'(base);
    len = W_LEN'(n);
    bus.m_ready = pick_ready(mode, 0);
    while (!finished && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      base_addr = W_WORD'($urandom);
      len = W_LEN'($urandom);
      if (n == 0) begin
        if (cyc == 1) check_eq("zero_done", done, 1'b1);
        else          check_eq("zero_done_once", done, 1'b0);
        check_eq("zero_busy", busy, 1'b0);
        check_eq("zero_en", bus.bram_en, 1'b0);
        check_eq("zero_valid", bus.m_valid, 1'b0);
        if (cyc == 3) finished = 1;
      end else if (last_hs >= 0 && cyc == last_hs + 1) begin
        check_eq("done_pulse", done, 1'b1);
        check_eq("busy_fall", busy, 1'b0);
        check_eq("bram_we", bus.bram_we, 1'b0);
`ifdef BRAM_RD_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt, 64'(stall_model));
`endif
        finished = 1;
      end else begin
        check_eq("busy", busy, 1'b1);
        check_eq("done_low", done, 1'b0);
        if (bus.bram_en) begin
          check_eq("addr", bus.bram_addr, 64'((base + issued) % DEPTH));
          check_eq("credit", (issued - accepted) < 2, 1'b1);
          check_eq("extra_read", issued < n, 1'b1);
          issued++;
        end
        if (prev_stall) begin
          check_eq("hold_valid", bus.m_valid, 1'b1);
          check_eq("hold_data", bus.m_data, prev_data);
          check_eq("hold_last", bus.m_last, prev_last);
        end
        if (bus.m_valid && first_valid < 0) begin
          first_valid = cyc;
          check_eq("latency", cyc, 2);
        end
        if (poke && cyc == 3) begin
          start = 1'b1;
          base_addr = W_WORD'(base + 5);
          len = 5'd7;
        end
        rdy = pick_ready(mode, cyc);
        bus.m_ready = rdy;
        if (busy && bus.m_valid && !rdy) stall_model++;
        if (bus.m_valid && rdy) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_word", 1'b1, 1'b0);
          end else begin
            exp_word = exp_q.pop_front();
            check_eq("data", bus.m_data, exp_word);
            check_eq("last", bus.m_last, accepted == n - 1);
            accepted++;
            if (accepted == n) last_hs = cyc;
          end
        end
        prev_stall = bus.m_valid & !rdy;
        prev_data = bus.m_data;
        prev_last = bus.m_last;
      end
    end
    start = 1'b0;
    if (!finished) check_eq("timeout", 1'b0, 1'b1);
    check_eq("reads_issued", issued, n);
    check_eq("words_delivered", accepted, n);
    $display("xfer base=%0d len=%0d mode=%0d poke=%0d cycles=%0d", base, n, mode, poke, cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_en"}, bus.bram_en, 1'b0);
    check_eq({tag, "_addr"}, bus.bram_addr, '0);
    check_eq({tag, "_valid"}, bus.m_valid, 1'b0);
    check_eq({tag, "_data"}, bus.m_data, '0);
    check_eq({tag, "_last"}, bus.m_last, 1'b0);
  endtask

  // Abort a 10-word transfer after its 3rd word with an asynchronous reset.
  task automatic reset_mid();
    int hs = 0, cyc = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = 4'd3;
    len = 5'd10;
    bus.m_ready = 1'b1;
    while (hs < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (bus.m_valid) hs++;
    end
    if (hs < 3) check_eq("rst_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_no_done", done, 1'b0);
      check_eq("rst_idle", busy, 1'b0);
    end
    $display("reset mid-transfer after %0d words", hs);
  endtask

  initial begin
    int b, n;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    bus.m_ready = 1'b0;
    bus.bram_dout = $urandom;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    run_xfer(0, 16, 0, 0);
    run_xfer(14, 4, 0, 0);
    run_xfer(5, 8, 1, 0);
    run_xfer(9, 0, 0, 0);
    run_xfer(2, 6, 0, 1);
    reset_mid();
    run_xfer(7, 2, 0, 0);
    run_xfer(1, 4, 3, 0);
    run_xfer(15, 31, 1, 1);
    for (int k = 0; k < 12; k++) begin
      b = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(0, 31);
      run_xfer(b, n, 2, (n >= 4) && ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
